// File: rtl/input_shift_register.sv
// ============================================================================
// Module      : input_shift_register
// Description : WIDTH-bit universal input register for the double-dabble
//               (binary-to-BCD) datapath. Parallel-loads an operand, then
//               shifts it out MSB-first on serial_out, filling the LSB from
//               serial_in. Asynchronous clear (all zeros, highest priority)
//               and preset (all ones).
//               Optional macro INPUT_SHIFT_REGISTER_SHIFT_CNT_EN adds a
//               saturating shift counter (shift_count) and shift_done flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         preset,
  input  logic [WIDTH-1:0]             parallel_in,
  input  logic                         serial_in,
  input  logic                         mode,
  output logic                         serial_out,
  output logic [WIDTH-1:0]             parallel_out
`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]   shift_count,
  output logic                         shift_done
`endif
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next state: load the operand when mode is high, otherwise shift left with
  // serial_in entering the LSB and the old MSB dropping off.
  always_comb begin
    shift_d = {shift_q[WIDTH-2:0], serial_in};
    if (mode) begin
      shift_d = parallel_in;
    end
  end

  // Register with asynchronous clear (wins over preset) and preset.
  always_ff @(posedge clk or posedge clear or posedge preset) begin
    if (clear) begin
      shift_q <= '0;
    end else if (preset) begin
      shift_q <= '1;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign serial_out   = shift_q[WIDTH-1];
  assign parallel_out = shift_q;

`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
  localparam int                 CNT_W      = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count shift edges since the last load, saturating once a full operand
  // has been shifted out.
  always_comb begin
    cnt_d = cnt_q;
    if (mode) begin
      cnt_d = '0;
    end else if (cnt_q != c_cnt_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter shares the register's asynchronous clear/preset behaviour, but
  // both of those return it to zero since no operand is in flight.
  always_ff @(posedge clk or posedge clear or posedge preset) begin
    if (clear || preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shift_count = cnt_q;
  assign shift_done  = (cnt_q == c_cnt_max);
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_shift_register.sv
// ============================================================================
// Module      : tb_input_shift_register
// Description : Directed self-checking bench for input_shift_register (WIDTH=8).
//               Counter checks are compiled in when
//               INPUT_SHIFT_REGISTER_SHIFT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_shift_register;

  localparam int WIDTH = 8;

  logic             clk;
  logic             clear;
  logic             preset;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in;
  logic             mode;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
  logic [3:0]       shift_count;
  logic             shift_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  input_shift_register #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .clear        (clear),
    .preset       (preset),
    .parallel_in  (parallel_in),
    .serial_in    (serial_in),
    .mode         (mode),
    .serial_out   (serial_out),
    .parallel_out (parallel_out)
`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
    ,
    .shift_count  (shift_count),
    .shift_done   (shift_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (parallel_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_q: got %h expected 00", parallel_out);
    end
    n_checks++;
    if (serial_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sout: got %b expected 0", serial_out);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    parallel_in = 8'hAF;
    mode        = 1'b1;
    tick();
    n_checks++;
    if (parallel_out !== 8'hAF) begin
      n_fail++;
      $display("FAIL load_q: got %h expected AF", parallel_out);
    end
    n_checks++;
    if (serial_out !== 1'b1) begin
      n_fail++;
      $display("FAIL load_sout: got %b expected 1", serial_out);
    end
  endtask

  task automatic test_async_clear();
    // Operand AF is in the register; clear between edges.
    @(negedge clk);
    #1 clear = 1'b1;
    #1;
    n_checks++;
    if (parallel_out !== 8'h00 || serial_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got q=%h sout=%b expected q=00 sout=0", parallel_out, serial_out);
    end
    preset = 1'b1;
    #1;
    n_checks++;
    if (parallel_out !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_over_preset: got %h expected 00", parallel_out);
    end
    preset = 1'b0;
    #1 clear = 1'b0;
  endtask

  task automatic test_preset();
    @(negedge clk);
    mode      = 1'b0;
    serial_in = 1'b0;
    #1 preset = 1'b1;
    #1;
    n_checks++;
    if (parallel_out !== 8'hFF || serial_out !== 1'b1) begin
      n_fail++;
      $display("FAIL async_preset: got q=%h sout=%b expected q=FF sout=1", parallel_out, serial_out);
    end
    preset = 1'b0;
    #1;
    n_checks++;
    if (parallel_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL preset_hold: got %h expected FF", parallel_out);
    end
    // First synchronous action after release is a shift.
    tick();
    n_checks++;
    if (parallel_out !== 8'hFE) begin
      n_fail++;
      $display("FAIL preset_first_edge: got %h expected FE", parallel_out);
    end
  endtask

  task automatic test_shift();
    logic [7:0] exp_q [12];
    logic       sin   [12];
    exp_q = '{8'h5E, 8'hBC, 8'h78, 8'hF0,
              8'hE1, 8'hC3, 8'h87, 8'h0F,
              8'h1E, 8'h3C, 8'h78, 8'hF0};
    sin   = '{1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mode      = 1'b0;
      serial_in = sin[i];
      tick();
      n_checks++;
      if (parallel_out !== exp_q[i] || serial_out !== exp_q[i][7]) begin
        n_fail++;
        $display("FAIL shift_%0d: got q=%h sout=%b expected q=%h sout=%b",
                 i, parallel_out, serial_out, exp_q[i], exp_q[i][7]);
      end
    end
  endtask

  task automatic test_flush();
    // Eight zero shifts empty any operand.
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      mode      = 1'b0;
      serial_in = 1'b0;
      tick();
    end
    n_checks++;
    if (parallel_out !== 8'h00) begin
      n_fail++;
      $display("FAIL flush: got %h expected 00", parallel_out);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    parallel_in = 8'hC5;
    mode        = 1'b1;
    tick();
    @(negedge clk);
    mode      = 1'b0;
    serial_in = 1'b1;
    tick();
    // C5 shifted once with 1 -> 8B; now abort mid-operand.
    n_checks++;
    if (parallel_out !== 8'h8B) begin
      n_fail++;
      $display("FAIL abort_pre: got %h expected 8B", parallel_out);
    end
    #2 clear = 1'b1;
    #1 clear = 1'b0;
    tick();
    n_checks++;
    if (parallel_out !== 8'h01) begin
      n_fail++;
      $display("FAIL abort_post: got %h expected 01", parallel_out);
    end
  endtask

`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
  task automatic test_shift_count();
    @(negedge clk);
    parallel_in = 8'h96;
    mode        = 1'b1;
    tick();
    n_checks++;
    if (shift_count !== 4'd0 || shift_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_load: got cnt=%0d done=%b expected cnt=0 done=0", shift_count, shift_done);
    end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      mode      = 1'b0;
      serial_in = 1'b0;
      tick();
      n_checks++;
      if (shift_count !== ((i > 8) ? 4'd8 : 4'(i)) || shift_done !== (i >= 8)) begin
        n_fail++;
        $display("FAIL cnt_shift_%0d: got cnt=%0d done=%b expected cnt=%0d done=%b",
                 i, shift_count, shift_done, (i > 8) ? 8 : i, (i >= 8));
      end
    end
    @(negedge clk);
    mode = 1'b1;
    tick();
    n_checks++;
    if (shift_count !== 4'd0 || shift_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_reload: got cnt=%0d done=%b expected cnt=0 done=0", shift_count, shift_done);
    end
    @(negedge clk);
    mode = 1'b0;
    tick();
    tick();
    #1 preset = 1'b1;
    #1;
    n_checks++;
    if (shift_count !== 4'd0) begin
      n_fail++;
      $display("FAIL cnt_preset: got cnt=%0d expected 0", shift_count);
    end
    preset = 1'b0;
  endtask
`endif

  initial begin
    clear       = 1'b1;
    preset      = 1'b0;
    parallel_in = '0;
    serial_in   = 1'b0;
    mode        = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    clear = 1'b0;
    test_load();
    test_async_clear();
    test_preset();
    test_load();
    test_shift();
    test_flush();
    test_abort();
`ifdef INPUT_SHIFT_REGISTER_SHIFT_CNT_EN
    test_shift_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion before 100000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/input_shift_register.md
Name: input_shift_register

Overview:
- WIDTH-bit universal input register feeding the double-dabble (binary-to-BCD) datapath.
- Parallel-loads a binary operand, then shifts it out MSB-first, one bit per clock, on serial_out.
- Supports serial fill from serial_in, plus asynchronous clear and preset.

Parameters:
- WIDTH, 8, register width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset; forces register to all zeros.
- preset  input  1  asynchronous, active-high preset; forces register to all ones.
- parallel_in  input  WIDTH  parallel load data.
- serial_in  input  1  serial data shifted into the LSB.
- mode  input  1  1 = parallel load, 0 = shift.
- serial_out  output  1  current MSB of register (q[WIDTH-1]).
- parallel_out  output  WIDTH  current register contents q.

Behaviour:
- One clock domain, clk. Reset (clear) is asynchronous and active-high. preset is also asynchronous and active-high.
- Internal state is q[WIDTH-1:0]. Outputs are combinational from q: serial_out = q[WIDTH-1], parallel_out = q. No output registers.
- Priority, highest first:
  - clear=1: q = 0 immediately, independent of clk; held while asserted.
  - preset=1 (clear=0): q = all ones immediately; held while asserted.
  - Rising clk edge, mode=1: q <= parallel_in (1-cycle latency).
  - Rising clk edge, mode=0: q <= {q[WIDTH-2:0], serial_in} (left shift, serial_in enters LSB, old MSB discarded).
- Reset values: q = 0, serial_out = 0, parallel_out = 0.
- clear and preset both asserted: clear wins, q = 0.
- Deassertion of clear/preset is asynchronous. The first synchronous action occurs on the next rising clk edge.
- Async assertion mid-shift: aborts the current operand. No partial state is retained.
- The register shifts on every clock while mode=0; there is no hold state.
- After WIDTH shifts with serial_in=0, q = 0. Shifting continues indefinitely; no wrap or stop.
- mode and serial_in must be stable around the rising edge (standard setup/hold). No handshake.

Optional Feature:
- Macro INPUT_SHIFT_REGISTER_SHIFT_CNT_EN.
- Defined, adds two outputs:
  - shift_count: $clog2(WIDTH+1) bits, cleared to 0 by clear, preset or a parallel load; increments on each shift edge and saturates at WIDTH.
  - shift_done: 1 bit, high when shift_count == WIDTH.
- Undefined: neither port nor its logic exists. Core behaviour is identical in both builds.

Test Plan:
- clear=1 pulsed between edges -> q=0x00 and serial_out=0 immediately, no clk edge required. With preset=1 also asserted -> q stays 0x00.
- preset=1, clear=0 -> q=0xFF and serial_out=1 immediately. On deassertion, q holds 0xFF until the next edge.
- WIDTH=8, parallel_in=0xAF, mode=1, one edge -> q=0xAF, serial_out=1.
- From 0xAF, mode=0, serial_in=0, 4 edges -> q sequence 0x5E, 0xBC, 0x78, 0xF0; serial_out 0, 1, 0, 1.
- Continue with serial_in=1, 4 edges -> 0xE1, 0xC3, 0x87, 0x0F. Then serial_in=0, 4 edges -> 0x1E, 0x3C, 0x78, 0xF0.
- With INPUT_SHIFT_REGISTER_SHIFT_CNT_EN defined: load, then 8 shifts -> shift_count 1..8; shift_done=1 after the 8th shift; count stays 8 on a 9th shift; a new load returns it to 0.
